calculator16_top: RTL and testbench
===================================

Name: calculator16_top

Overview:
- 16-bit signed keypad calculator top level.
- Scans a 4x4 matrix keypad, debounces key presses and accumulates two decimal operands, each with an optional sign.
- Applies +, - or * and drives the 16-bit two's-complement result to the display with a completion flag.
- Contains the keypad input controller (input_ctrl_inst) and the general calculation controller (gencon_inst).

Parameters:
- WIDTH, 16, operand/result width; the design is verified at 16 only.
- DEBOUNCE_CYCLES, 2, number of consecutive stable cycles a row press must hold before it is accepted.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- nRST  input  1  reset, synchronous and active-high despite the name; clears all state.
- RowIn  input  4  keypad rows, active-low; a bit is 0 while a key in that row is pressed.
- ColOut  output  4  column drive, one-hot-low (~(1<<col)).
- display_output  output  16  current operand during entry; result after '='.
- input_state_FPGA  output  2  controller state (0 OP1, 1 OP2, 2 CALC, 3 DONE).
- complete  output  1  high while in DONE.
- key_pressed  output  1  high while the input FSM is in HOLD (state 3).

Behaviour:
- Key index = row*4 + col.
- Key map: 0:'1' 1:'2' 2:'3' 3:ADD; 4:'4' 5:'5' 6:'6' 7:SUB; 8:'7' 9:'8' 10:'9' 11:MULT; 12:EQ 13:'0' 14:CLR 15:NEG.
- Reset values: ColOut=4'b1110, display_output=0, complete=0, key_pressed=0, both FSMs in state 0, operands, sign flags, operator and result all 0.
- Input FSM, state register input_control_state (2-bit):
  - 0 IDLE: if RowIn==4'hF, rotate the column (0->1->2->3->0) every clock; otherwise freeze the column, latch row (lowest zero bit) and col, go to 1.
  - 1 DEBOUNCE: count while RowIn still shows the latched row low; after DEBOUNCE_CYCLES go to 2; on mismatch go back to 0.
  - 2 VALID: present the key code, go to 3.
  - 3 HOLD: key_pressed=1; the controller pulses key_read one cycle (the cycle after entry); stay until RowIn==4'hF, then go to 0.
  - Exactly one key_read per physical press; no auto-repeat.
- Controller (gencon_inst), acts only on a key_read pulse:
  - OP1: a digit sets op1=op1*10+d, truncated to 16 bits. NEG toggles neg1. ADD/SUB/MULT latch the operator and go to OP2. EQ takes operator=ADD with op2=0 and goes to CALC.
  - OP2: digits and NEG act on op2/neg2. Further operators overwrite the operator. EQ goes to CALC.
  - Effective operand = neg ? -op : op (16-bit two's complement).
  - CALC: ADD/SUB finish in 1 cycle. MULT is a sequential shift-add over 16 cycles on the magnitudes; the sign is applied as the XOR of the operand signs.
  - Result = low 16 bits of the exact signed result; overflow wraps silently.
  - DONE: complete=1, display_output=result. Any digit key clears everything and restarts OP1 with that digit; other keys are ignored.
- Display: in OP1 shows the signed op1, in OP2 shows the signed op2, in CALC holds its previous value.
- nRST in any state aborts the operation and restores the reset values on the next edge.
- RowIn with several bits low: the lowest-numbered row wins.

Optional Feature:
- CALC_CLEAR_KEY_EN:
  - Defined: key 14 (CLR) in any controller state clears operands, signs, operator and complete, and returns to OP1.
  - Undefined: key 14 is debounced and acknowledged but has no effect.

Decomposition:
- Package calculator_pkg holds:
  - key index constants (KEY_ADD=3, KEY_SUB=7, KEY_MULT=11, KEY_EQ=12, KEY_CLR=14, KEY_NEG=15);
  - the digit-map function;
  - enums for the input FSM states (IDLE/DEBOUNCE/VALID/HOLD) and the controller states (OP1/OP2/CALC/DONE).
- One natural sub-module: seq_multiplier16, a start/done shift-add unit.
- Hierarchy names input_ctrl_inst (with input_control_state) and gencon_inst (with key_read) are mandatory; benches probe them.

Test Plan:
- NEG,3,MULT,NEG,4,EQ -> complete=1, display_output=12.
- 63 MULT 41 EQ -> 2583; 456 MULT 0 EQ -> 0.
- 13107 MULT NEG 5 EQ -> display_output=16'h0001 (wrapped -65535); 32767 MULT 2 EQ -> 16'hFFFE.
- 123 ADD 45 EQ -> 168; 123 SUB 45 EQ -> 78; 0 SUB 0 EQ -> 0.
- Held key over 50 cycles -> single key_read, a single digit accumulated. 1-cycle RowIn glitch -> no key accepted, FSM back at 0.
- nRST asserted mid-multiply -> next edge complete=0, display_output=0, ColOut=4'b1110; a fresh sequence then computes correctly.

Source files
------------

// File: rtl/calculator_pkg.sv
// Shared definitions for the 16-bit keypad calculator.
//   - Key index constants for the non-digit keys of the 4x4 matrix
//     (key index = row*4 + col).
//   - State enums for the keypad input FSM and the calculation controller.
//   - Operator enum and key decode helpers (digit test, digit value,
//     operator select).
package calculator_pkg;

  localparam logic [3:0] KEY_ADD  = 4'd3;
  localparam logic [3:0] KEY_SUB  = 4'd7;
  localparam logic [3:0] KEY_MULT = 4'd11;
  localparam logic [3:0] KEY_EQ   = 4'd12;
  localparam logic [3:0] KEY_CLR  = 4'd14;
  localparam logic [3:0] KEY_NEG  = 4'd15;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    VALID    = 2'd2,
    HOLD     = 2'd3
  } input_state_t;

  typedef enum logic [1:0] {
    OP1  = 2'd0,
    OP2  = 2'd1,
    CALC = 2'd2,
    DONE = 2'd3
  } ctrl_state_t;

  typedef enum logic [1:0] {
    OPR_ADD  = 2'd0,
    OPR_SUB  = 2'd1,
    OPR_MULT = 2'd2
  } operator_t;

  // Digits occupy rows 0-2 / cols 0-2, plus '0' at key 13.
  function automatic logic key_is_digit(input logic [3:0] key);
    return ((key[3:2] != 2'd3) && (key[1:0] != 2'd3)) || (key == 4'd13);
  endfunction

  function automatic logic [3:0] key_digit(input logic [3:0] key);
    logic [3:0] d;
    case (key)
      4'd0:    d = 4'd1;
      4'd1:    d = 4'd2;
      4'd2:    d = 4'd3;
      4'd4:    d = 4'd4;
      4'd5:    d = 4'd5;
      4'd6:    d = 4'd6;
      4'd8:    d = 4'd7;
      4'd9:    d = 4'd8;
      4'd10:   d = 4'd9;
      default: d = 4'd0;
    endcase
    return d;
  endfunction

  function automatic operator_t key_operator(input logic [3:0] key);
    operator_t o;
    case (key)
      KEY_SUB:  o = OPR_SUB;
      KEY_MULT: o = OPR_MULT;
      default:  o = OPR_ADD;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/calculator16_gencon.sv
// General calculation controller.
//   clk, nRST      : clock, synchronous active-high reset
//   key_pressed    : high while the keypad FSM is in HOLD
//   key_code       : accepted key index
//   display_output : signed operand during entry, result in DONE
//   ctrl_state     : OP1/OP2/CALC/DONE encoding
//   complete       : high while in DONE
// key_read is the first HOLD cycle, so every physical press yields one pulse.
// Optional CALC_CLEAR_KEY_EN: key 14 clears everything from any state.
module gencon
  import calculator_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             nRST,
  input  logic             key_pressed,
  input  logic [3:0]       key_code,
  output logic [WIDTH-1:0] display_output,
  output logic [1:0]       ctrl_state,
  output logic             complete
);

  ctrl_state_t             state;
  ctrl_state_t             state_nxt;
  operator_t               oper;
  logic [WIDTH-1:0]        op1;
  logic [WIDTH-1:0]        op2;
  logic                    neg1;
  logic                    neg2;
  logic signed [WIDTH-1:0] eff1;
  logic signed [WIDTH-1:0] eff2;
  logic signed [WIDTH-1:0] result;
  logic signed [WIDTH-1:0] disp_hold;
  logic [WIDTH-1:0]        mag1;
  logic [WIDTH-1:0]        mag2;
  logic [WIDTH-1:0]        mul_product;
  logic                    mul_neg;
  logic                    mul_busy;
  logic                    mul_start;
  logic                    mul_done;
  logic                    key_pressed_q;
  logic                    key_read;
  logic                    clr_hit;
  logic                    is_digit;
  logic                    is_oper;
  logic [3:0]              digit;

  function automatic logic [WIDTH-1:0] shift_in_digit(input logic [WIDTH-1:0] v,
                                                      input logic [3:0] d);
    return (v << 3) + (v << 1) + WIDTH'(d);
  endfunction

  assign key_read = key_pressed & ~key_pressed_q;
  assign is_digit = key_is_digit(key_code);
  assign digit    = key_digit(key_code);
  assign is_oper  = (key_code == KEY_ADD) || (key_code == KEY_SUB) || (key_code == KEY_MULT);

`ifdef CALC_CLEAR_KEY_EN
  assign clr_hit = key_read && (key_code == KEY_CLR);
`else
  assign clr_hit = 1'b0;
`endif

  assign eff1    = $signed(neg1 ? -op1 : op1);
  assign eff2    = $signed(neg2 ? -op2 : op2);
  // Multiply on magnitudes; sign restored from the operand signs.
  assign mag1    = eff1[WIDTH-1] ? $unsigned(-eff1) : $unsigned(eff1);
  assign mag2    = eff2[WIDTH-1] ? $unsigned(-eff2) : $unsigned(eff2);
  assign mul_neg = eff1[WIDTH-1] ^ eff2[WIDTH-1];

  seq_multiplier16 #(.WIDTH(WIDTH)) mult_inst (
    .clk     (clk),
    .nRST    (nRST),
    .start   (mul_start),
    .a       (mag1),
    .b       (mag2),
    .done    (mul_done),
    .product (mul_product)
  );

  always_ff @(posedge clk) begin
    if (nRST) state <= OP1;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mul_start = 1'b0;
    if (clr_hit) begin
      state_nxt = OP1;
    end else begin
      case (state)
        OP1: if (key_read) begin
          if (is_oper)                  state_nxt = OP2;
          else if (key_code == KEY_EQ)  state_nxt = CALC;
        end
        OP2: if (key_read && key_code == KEY_EQ) state_nxt = CALC;
        CALC: begin
          if (oper != OPR_MULT)  state_nxt = DONE;
          else if (!mul_busy)    mul_start = 1'b1;
          else if (mul_done)     state_nxt = DONE;
        end
        DONE: if (key_read && is_digit) state_nxt = OP1;
        default: state_nxt = OP1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (nRST) begin
      op1           <= '0;
      op2           <= '0;
      neg1          <= 1'b0;
      neg2          <= 1'b0;
      oper          <= OPR_ADD;
      result        <= '0;
      disp_hold     <= '0;
      mul_busy      <= 1'b0;
      key_pressed_q <= 1'b0;
    end else begin
      key_pressed_q <= key_pressed;
      if (state != CALC) disp_hold <= display_output;
      if (clr_hit) begin
        op1      <= '0;
        op2      <= '0;
        neg1     <= 1'b0;
        neg2     <= 1'b0;
        oper     <= OPR_ADD;
        mul_busy <= 1'b0;
      end else begin
        case (state)
          OP1: if (key_read) begin
            if (is_digit)                 op1 <= shift_in_digit(op1, digit);
            else if (key_code == KEY_NEG) neg1 <= ~neg1;
            else if (is_oper)             oper <= key_operator(key_code);
            else if (key_code == KEY_EQ) begin
              oper <= OPR_ADD;
              op2  <= '0;
              neg2 <= 1'b0;
            end
          end
          OP2: if (key_read) begin
            if (is_digit)                 op2 <= shift_in_digit(op2, digit);
            else if (key_code == KEY_NEG) neg2 <= ~neg2;
            else if (is_oper)             oper <= key_operator(key_code);
          end
          CALC: begin
            case (oper)
              OPR_ADD: result <= eff1 + eff2;
              OPR_SUB: result <= eff1 - eff2;
              default: begin
                if (!mul_busy) begin
                  mul_busy <= 1'b1;
                end else if (mul_done) begin
                  mul_busy <= 1'b0;
                  result   <= mul_neg ? $signed(-mul_product) : $signed(mul_product);
                end
              end
            endcase
          end
          DONE: if (key_read && is_digit) begin
            op1    <= WIDTH'(digit);
            op2    <= '0;
            neg1   <= 1'b0;
            neg2   <= 1'b0;
            oper   <= OPR_ADD;
            result <= '0;
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    display_output = disp_hold;
    case (state)
      OP1:     display_output = eff1;
      OP2:     display_output = eff2;
      DONE:    display_output = result;
      default: display_output = disp_hold;
    endcase
  end

  assign ctrl_state = state;
  assign complete   = (state == DONE);

endmodule

// File: rtl/calculator16_input_ctrl.sv
// Keypad scanner and debouncer.
//   clk, nRST    : clock, synchronous active-high reset
//   RowIn        : active-low row inputs
//   ColOut       : one-hot-low column drive
//   key_code     : {row, col} of the accepted key, valid from HOLD onward
//   key_pressed  : high while the FSM sits in HOLD
// The column rotates every idle clock; once a row goes low the column is
// frozen so the same key stays visible through debounce and hold.
module input_ctrl
  import calculator_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       nRST,
  input  logic [3:0] RowIn,
  output logic [3:0] ColOut,
  output logic [3:0] key_code,
  output logic       key_pressed
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  input_state_t     input_control_state;
  input_state_t     state_nxt;
  logic [1:0]       col;
  logic [1:0]       row;
  logic [1:0]       row_low;
  logic [CNT_W-1:0] cnt;

  // Lowest-numbered active row wins when several are low.
  always_comb begin
    row_low = 2'd3;
    if (!RowIn[0])      row_low = 2'd0;
    else if (!RowIn[1]) row_low = 2'd1;
    else if (!RowIn[2]) row_low = 2'd2;
  end

  always_ff @(posedge clk) begin
    if (nRST) input_control_state <= IDLE;
    else      input_control_state <= state_nxt;
  end

  always_comb begin
    state_nxt = input_control_state;
    case (input_control_state)
      IDLE:     if (RowIn != 4'hF) state_nxt = DEBOUNCE;
      DEBOUNCE: begin
        if (RowIn[row])           state_nxt = IDLE;
        else if (cnt == CNT_LAST) state_nxt = VALID;
      end
      VALID:    state_nxt = HOLD;
      HOLD:     if (RowIn == 4'hF) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (nRST) begin
      col      <= 2'd0;
      row      <= 2'd0;
      cnt      <= '0;
      key_code <= 4'd0;
    end else begin
      case (input_control_state)
        IDLE: begin
          cnt <= '0;
          if (RowIn == 4'hF) col <= col + 2'd1;
          else               row <= row_low;
        end
        DEBOUNCE: if (!RowIn[row]) cnt <= cnt + CNT_W'(1);
        VALID:    key_code <= {row, col};
        default:  ;
      endcase
    end
  end

  assign ColOut      = ~(4'b0001 << col);
  assign key_pressed = (input_control_state == HOLD);

endmodule

// File: rtl/calculator16_seq_multiplier16.sv
// Sequential shift-add multiplier, one partial product per clock.
//   clk, nRST : clock, synchronous active-high reset (control only)
//   start     : load operands and begin; may restart at any time
//   a, b      : unsigned operands
//   done      : rises after WIDTH iterations, holds until the next start
//   product   : low WIDTH bits of a*b, valid while done is high
// Only the low WIDTH bits of the product are kept; those depend only on
// the low WIDTH bits of every partial product, so everything stays WIDTH wide.
module seq_multiplier16 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             nRST,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             busy;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;

  always_ff @(posedge clk) begin
    if (nRST) begin
      busy <= 1'b0;
      done <= 1'b0;
      cnt  <= '0;
    end else if (start) begin
      busy <= 1'b1;
      done <= 1'b0;
      cnt  <= CNT_W'(WIDTH);
    end else if (busy) begin
      cnt <= cnt - CNT_W'(1);
      if (cnt == CNT_W'(1)) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (start) begin
      acc    <= '0;
      mcand  <= a;
      mplier <= b;
    end else if (busy) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end

  assign product = acc;

endmodule

// File: rtl/calculator16_top.sv
// 16-bit signed keypad calculator, top level.
//   clk              : system clock, rising edge
//   nRST             : synchronous reset, active-high
//   RowIn            : keypad rows, active-low
//   ColOut           : keypad column drive, one-hot-low
//   display_output   : operand during entry, result after '='
//   input_state_FPGA : controller state (0 OP1, 1 OP2, 2 CALC, 3 DONE)
//   complete         : high while the result is shown
//   key_pressed      : high while a debounced key is held
// Optional build macro CALC_CLEAR_KEY_EN enables the CLR key (key 14).
module calculator16_top
  import calculator_pkg::*;
#(
  parameter int WIDTH           = 16,
  parameter int DEBOUNCE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             nRST,
  input  logic [3:0]       RowIn,
  output logic [3:0]       ColOut,
  output logic [WIDTH-1:0] display_output,
  output logic [1:0]       input_state_FPGA,
  output logic             complete,
  output logic             key_pressed
);

  logic [3:0] key_code;

  input_ctrl #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) input_ctrl_inst (
    .clk         (clk),
    .nRST        (nRST),
    .RowIn       (RowIn),
    .ColOut      (ColOut),
    .key_code    (key_code),
    .key_pressed (key_pressed)
  );

  gencon #(.WIDTH(WIDTH)) gencon_inst (
    .clk            (clk),
    .nRST           (nRST),
    .key_pressed    (key_pressed),
    .key_code       (key_code),
    .display_output (display_output),
    .ctrl_state     (input_state_FPGA),
    .complete       (complete)
  );

endmodule

// File: tb/tb_calculator16_top.sv
// Bench for calculator16_top: keypad model, directed plan cases and random
// key streams scored against an arithmetic model of the calculator rules.
module tb_calculator16_top;
  import calculator_pkg::*;

  logic        clk = 1'b0;
  logic        nRST = 1'b1;
  logic [3:0]  RowIn;
  logic [3:0]  ColOut;
  logic [15:0] display_output;
  logic [1:0]  input_state_FPGA;
  logic        complete;
  logic        key_pressed;

  calculator16_top dut (
    .clk              (clk),
    .nRST             (nRST),
    .RowIn            (RowIn),
    .ColOut           (ColOut),
    .display_output   (display_output),
    .input_state_FPGA (input_state_FPGA),
    .complete         (complete),
    .key_pressed      (key_pressed)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int kr_count = 0;

  // Keypad: the held key pulls its row low only while its column is driven.
  logic       key_down = 1'b0;
  logic [3:0] key_idx = 4'd0;
  logic       glitch_en = 1'b0;
  logic [3:0] glitch_val = 4'hF;

  always_comb begin
    RowIn = 4'hF;
    if (glitch_en) RowIn = glitch_val;
    else if (key_down && !ColOut[key_idx[1:0]]) RowIn[key_idx[3:2]] = 1'b0;
  end

  always @(posedge clk) if (dut.gencon_inst.key_read) kr_count <= kr_count + 1;

  // ---------------- reference model ----------------
  int keymap[16] = '{1, 2, 3, -1, 4, 5, 6, -1, 7, 8, 9, -1, -1, 0, -1, -1};
  int dkey[10]   = '{13, 0, 1, 2, 4, 5, 6, 8, 9, 10};
  int m_state, m_op1, m_op2, m_neg1, m_neg2, m_oper, m_result;

  function automatic int eff(int op, int neg);
    return neg ? (65536 - op) % 65536 : op;
  endfunction

  function automatic longint as_signed(int v);
    return (v >= 32768) ? longint'(v) - 65536 : longint'(v);
  endfunction

  function automatic void m_clear();
    m_state = 0; m_op1 = 0; m_op2 = 0; m_neg1 = 0; m_neg2 = 0; m_oper = 0; m_result = 0;
  endfunction

  function automatic void m_compute();
    longint a, b, r;
    a = as_signed(eff(m_op1, m_neg1));
    b = as_signed(eff(m_op2, m_neg2));
    case (m_oper)
      0: r = a + b;
      1: r = a - b;
      default: r = a * b;
    endcase
    m_result = int'(r & 64'hFFFF);
    m_state = 3;
  endfunction

  function automatic void model_key(int k);
    int d;
    d = keymap[k];
`ifdef CALC_CLEAR_KEY_EN
    if (k == 14) begin m_clear(); return; end
`endif
    case (m_state)
      0: begin
        if (d >= 0) m_op1 = (m_op1 * 10 + d) % 65536;
        else if (k == 15) m_neg1 ^= 1;
        else if (k == 3 || k == 7 || k == 11) begin m_oper = (k - 3) / 4; m_state = 1; end
        else if (k == 12) begin m_oper = 0; m_op2 = 0; m_neg2 = 0; m_compute(); end
      end
      1: begin
        if (d >= 0) m_op2 = (m_op2 * 10 + d) % 65536;
        else if (k == 15) m_neg2 ^= 1;
        else if (k == 3 || k == 7 || k == 11) m_oper = (k - 3) / 4;
        else if (k == 12) m_compute();
      end
      3: if (d >= 0) begin m_clear(); m_op1 = d; end
      default: ;
    endcase
  endfunction

  function automatic int m_display();
    case (m_state)
      0: return eff(m_op1, m_neg1);
      1: return eff(m_op2, m_neg2);
      default: return m_result;
    endcase
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic press(input int k, input int hold);
    int start, n;
    start = kr_count;
    @(negedge clk);
    key_idx = 4'(k);
    key_down = 1'b1;
    n = 0;
    while (kr_count == start && n < 100) begin @(negedge clk); n++; end
    repeat (hold) @(negedge clk);
    key_down = 1'b0;
    n = 0;
    while (dut.input_ctrl_inst.input_control_state != IDLE && n < 20) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
    model_key(k);
    checks++;
    if (kr_count !== start + 1) begin
      errors++;
      $display("FAIL key_read_count key=%0d got=%0d expected=1", k, kr_count - start);
    end
  endtask

  task automatic enter_num(input int n);
    int ds[$];
    int v;
    v = n;
    if (v == 0) ds.push_back(0);
    while (v > 0) begin ds.push_front(v % 10); v /= 10; end
    foreach (ds[i]) press(dkey[ds[i]], 2);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!complete && n < 80) begin @(negedge clk); n++; end
  endtask

  task automatic do_reset();
    @(negedge clk);
    nRST = 1'b1; key_down = 1'b0; glitch_en = 1'b0;
    repeat (2) @(negedge clk);
    nRST = 1'b0;
    m_clear();
  endtask

  typedef struct {int na; int a; int op; int nb; int b; int exp;} vec_t;

  task automatic run_vec(input vec_t v);
    do_reset();
    if (v.na != 0) press(KEY_NEG, 2);
    enter_num(v.a);
    press(v.op, 2);
    if (v.nb != 0) press(KEY_NEG, 2);
    enter_num(v.b);
    press(KEY_EQ, 2);
    wait_done();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    nRST = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (ColOut !== 4'b1110) begin errors++; $display("FAIL reset_colout got=%b expected=1110", ColOut); end
    checks++; if (display_output !== 16'd0) begin errors++; $display("FAIL reset_display got=%0d expected=0", display_output); end
    checks++; if (complete !== 1'b0) begin errors++; $display("FAIL reset_complete got=%b expected=0", complete); end
    checks++; if (key_pressed !== 1'b0) begin errors++; $display("FAIL reset_key_pressed got=%b expected=0", key_pressed); end
    checks++; if (input_state_FPGA !== 2'd0) begin errors++; $display("FAIL reset_ctrl_state got=%0d expected=0", input_state_FPGA); end
    checks++; if (dut.input_ctrl_inst.input_control_state !== IDLE) begin errors++; $display("FAIL reset_input_state got=%0d expected=0", dut.input_ctrl_inst.input_control_state); end
    @(negedge clk);
    nRST = 1'b0;
    m_clear();
  endtask

  task automatic test_mult();
    vec_t tv[5] = '{
      '{1, 3, 11, 1, 4, 12},
      '{0, 63, 11, 0, 41, 2583},
      '{0, 456, 11, 0, 0, 0},
      '{0, 13107, 11, 1, 5, 16'h0001},
      '{0, 32767, 11, 0, 2, 16'hFFFE}
    };
    foreach (tv[i]) begin
      run_vec(tv[i]);
      checks++; if (display_output !== 16'(tv[i].exp)) begin errors++; $display("FAIL mult_%0d display got=%h expected=%h", i, display_output, 16'(tv[i].exp)); end
      checks++; if (complete !== 1'b1) begin errors++; $display("FAIL mult_%0d complete got=%b expected=1", i, complete); end
    end
  endtask

  task automatic test_addsub();
    vec_t tv[3] = '{'{0, 123, 3, 0, 45, 168}, '{0, 123, 7, 0, 45, 78}, '{0, 0, 7, 0, 0, 0}};
    do_reset();
    enter_num(123);
    checks++; if (display_output !== 16'd123) begin errors++; $display("FAIL entry_op1 got=%0d expected=123", display_output); end
    press(KEY_ADD, 2);
    checks++; if (input_state_FPGA !== 2'd1) begin errors++; $display("FAIL entry_state got=%0d expected=1", input_state_FPGA); end
    foreach (tv[i]) begin
      run_vec(tv[i]);
      checks++; if (display_output !== 16'(tv[i].exp)) begin errors++; $display("FAIL addsub_%0d display got=%0d expected=%0d", i, display_output, tv[i].exp); end
      checks++; if (complete !== 1'b1) begin errors++; $display("FAIL addsub_%0d complete got=%b expected=1", i, complete); end
    end
  endtask

  task automatic test_done_keys();
    press(KEY_ADD, 2);
    checks++; if (display_output !== 16'd0 || complete !== 1'b1) begin errors++; $display("FAIL done_ignore display=%0d complete=%b expected 0/1", display_output, complete); end
    press(dkey[7], 2);
    checks++; if (display_output !== 16'd7 || input_state_FPGA !== 2'd0) begin errors++; $display("FAIL done_restart display=%0d state=%0d expected 7/0", display_output, input_state_FPGA); end
  endtask

  task automatic test_hold();
    int start;
    do_reset();
    start = kr_count;
    press(dkey[7], 50);
    checks++; if (kr_count - start !== 1) begin errors++; $display("FAIL hold_reads got=%0d expected=1", kr_count - start); end
    checks++; if (display_output !== 16'd7) begin errors++; $display("FAIL hold_display got=%0d expected=7", display_output); end
  endtask

  task automatic test_glitch();
    int start;
    do_reset();
    start = kr_count;
    @(negedge clk);
    glitch_val = 4'b1011; glitch_en = 1'b1;
    @(negedge clk);
    checks++; if (dut.input_ctrl_inst.input_control_state !== DEBOUNCE) begin errors++; $display("FAIL glitch_enter got=%0d expected=1", dut.input_ctrl_inst.input_control_state); end
    glitch_en = 1'b0;
    @(negedge clk);
    checks++; if (dut.input_ctrl_inst.input_control_state !== IDLE) begin errors++; $display("FAIL glitch_return got=%0d expected=0", dut.input_ctrl_inst.input_control_state); end
    repeat (10) @(negedge clk);
    checks++; if (kr_count !== start || display_output !== 16'd0) begin errors++; $display("FAIL glitch_accept reads=%0d display=%0d expected 0/0", kr_count - start, display_output); end
  endtask

  task automatic test_reset_mid_mult();
    do_reset();
    enter_num(63);
    press(KEY_MULT, 2);
    enter_num(41);
    press(KEY_EQ, 2);
    checks++; if (input_state_FPGA !== 2'd2) begin errors++; $display("FAIL midmult_state got=%0d expected=2", input_state_FPGA); end
    @(negedge clk);
    nRST = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (complete !== 1'b0 || display_output !== 16'd0 || ColOut !== 4'b1110) begin
      errors++; $display("FAIL midmult_reset complete=%b display=%0d colout=%b expected 0/0/1110", complete, display_output, ColOut);
    end
    @(negedge clk);
    nRST = 1'b0;
    m_clear();
    enter_num(25);
    press(KEY_MULT, 2);
    press(KEY_NEG, 2);
    enter_num(4);
    press(KEY_EQ, 2);
    wait_done();
    checks++; if (display_output !== 16'hFF9C || complete !== 1'b1) begin errors++; $display("FAIL midmult_fresh display=%h complete=%b expected ff9c/1", display_output, complete); end
  endtask

  task automatic test_random();
    int ops[3] = '{3, 7, 11};
    int seq[$];
    int ds[$];
    int v;
    do_reset();
    for (int it = 0; it < 20; it++) begin
      seq.delete();
      if ($urandom % 4 == 0) seq.push_back(15);
      for (int part = 0; part < 2; part++) begin
        v = (part == 0) ? int'($urandom_range(0, 99999)) : int'($urandom_range(0, 999));
        ds.delete();
        if (v == 0) ds.push_back(0);
        while (v > 0) begin ds.push_front(v % 10); v /= 10; end
        foreach (ds[j]) seq.push_back(dkey[ds[j]]);
        if (part == 0) begin
          if ($urandom % 4 == 0) seq.push_back(15);
          if ($urandom % 5 == 0) seq.push_back(14);
          if ($urandom % 6 == 0) break;
          seq.push_back(ops[$urandom % 3]);
          if ($urandom % 4 == 0) seq.push_back(ops[$urandom % 3]);
          if ($urandom % 3 == 0) seq.push_back(15);
        end
      end
      seq.push_back(12);
      foreach (seq[j]) begin
        press(seq[j], 2);
        if (m_state == 3) wait_done();
        checks++; if (display_output !== 16'(m_display())) begin errors++; $display("FAIL rand_display it=%0d key=%0d got=%h expected=%h", it, seq[j], display_output, 16'(m_display())); end
        checks++; if (input_state_FPGA !== 2'(m_state)) begin errors++; $display("FAIL rand_state it=%0d key=%0d got=%0d expected=%0d", it, seq[j], input_state_FPGA, m_state); end
        checks++; if (complete !== (m_state == 3)) begin errors++; $display("FAIL rand_complete it=%0d key=%0d got=%b expected=%b", it, seq[j], complete, m_state == 3); end
      end
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    m_clear();
    test_reset();
    test_addsub();
    test_done_keys();
    test_mult();
    test_hold();
    test_glitch();
    test_reset_mid_mult();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
